// File: rtl/rc4_pkg.sv
// Shared types and sizes for the RC4 key-schedule block: S-box geometry,
// controller state encoding and the S-box write-port payload.
package rc4_pkg;

  localparam int unsigned SBOX_DEPTH = 16;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned KEY_W      = SBOX_DEPTH * NIBBLE_W;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [SBOX_DEPTH-1:0][NIBBLE_W-1:0] nibble_arr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CALC_J,
    ST_SWAP,
    ST_DONE
  } state_e;

  // Two independent write lanes so a swap lands in a single cycle
  typedef struct packed {
    logic    we_a;
    nibble_t addr_a;
    nibble_t data_a;
    logic    we_b;
    nibble_t addr_b;
    nibble_t data_b;
  } sbox_wr_t;

endpackage

// File: rtl/sbox_regfile.sv
// 16 x 4-bit S-box storage: one external read port, two internal read ports
// for the controller and a two-lane write used for init and swap.
module sbox_regfile
  import rc4_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  sbox_wr_t wr_i,
  input  nibble_t  ext_addr_i,
  output nibble_t  ext_data_o,
  input  nibble_t  a_addr_i,
  output nibble_t  a_data_o,
  input  nibble_t  b_addr_i,
  output nibble_t  b_data_o
);

  nibble_arr_t mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      if (wr_i.we_a) mem_q[wr_i.addr_a] <= wr_i.data_a;
      if (wr_i.we_b) mem_q[wr_i.addr_b] <= wr_i.data_b;
    end
  end

  assign ext_data_o = mem_q[ext_addr_i];
  assign a_data_o   = mem_q[a_addr_i];
  assign b_data_o   = mem_q[b_addr_i];

endmodule

// File: rtl/rc4_ksa_ctrl.sv
// RC4 key-scheduling controller: runs INIT then 16 CALC_J/SWAP rounds over a
// 16-entry nibble S-box and flags the finished permutation with sbox_valid.
module rc4_ksa_ctrl
  import rc4_pkg::*;
#(
  parameter int unsigned N_SBOX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_W-1:0]    key,
  input  logic [NIBBLE_W-1:0] key_len,
  output logic                busy,
  output logic                done,
  output logic                sbox_valid,
  input  logic [NIBBLE_W-1:0] rd_addr,
  output logic [NIBBLE_W-1:0] rd_data
);

  localparam nibble_t LAST_IDX = NIBBLE_W'(N_SBOX - 1);

  state_e      state_q, state_d;
  nibble_t     k_q, k_d;
  nibble_t     i_q, i_d;
  nibble_t     j_q, j_d;
  nibble_t     kidx_q, kidx_d;
  nibble_t     klast_q, klast_d;
  nibble_arr_t key_q, key_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;

  sbox_wr_t    wr_c;
  nibble_t     s_i, s_j;

  sbox_regfile u_sbox (
    .clk        (clk),
    .rst_n      (reset),
    .wr_i       (wr_c),
    .ext_addr_i (rd_addr),
    .ext_data_o (rd_data),
    .a_addr_i   (i_q),
    .a_data_o   (s_i),
    .b_addr_i   (j_q),
    .b_data_o   (s_j)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      klast_q <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      klast_q <= klast_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    klast_d = klast_q;
    key_d   = key_q;
    valid_d = valid_q;
    wr_c    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          key_d   = key;
          // key_len of 0 wraps to 15, i.e. a 16-nibble key
          klast_d = key_len - 4'd1;
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          valid_d = 1'b0;
        end
      end
      ST_INIT: begin
        wr_c.we_a   = 1'b1;
        wr_c.addr_a = k_q;
        wr_c.data_a = k_q;
        k_d         = k_q + 4'd1;
        if (k_q == LAST_IDX) state_d = ST_CALC_J;
      end
      ST_CALC_J: begin
        j_d     = j_q + s_i + key_q[kidx_q];
        state_d = ST_SWAP;
      end
      ST_SWAP: begin
        wr_c.we_a   = 1'b1;
        wr_c.addr_a = i_q;
        wr_c.data_a = s_j;
        wr_c.we_b   = 1'b1;
        wr_c.addr_b = j_q;
        wr_c.data_b = s_i;
        kidx_d      = (kidx_q == klast_q) ? '0 : kidx_q + 4'd1;
        if (i_q == LAST_IDX) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
        end else begin
          i_d     = i_q + 4'd1;
          state_d = ST_CALC_J;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sbox_valid = valid_q;

endmodule

// File: doc/rc4_ksa_ctrl.md
RC4_KSA_CTRL -- requirements
Module: rc4_ksa_ctrl

Interface
REQ-001 SHALL have parameter N_SBOX, default 16, meaning the number of 4-bit S-box entries; it is fixed at 16 (index width 4).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port start, input, 1 bit: request to run a key schedule; sampled only in IDLE.
REQ-005 SHALL have port key, input, 64 bits: 16 key nibbles, nibble k at bits [4k+3:4k]; latched on accepted start.
REQ-006 SHALL have port key_len, input, 4 bits: key length in nibbles, 1..15 literal, 0 means 16; latched on accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse on completion.
REQ-009 SHALL have port sbox_valid, output, 1 bit: S-box holds a completed schedule.
REQ-010 SHALL have port rd_addr, input, 4 bits: S-box read index.
REQ-011 SHALL have port rd_data, output, 4 bits: combinational S[rd_addr], valid in every state.

Function
REQ-012 SHALL implement FSM states IDLE, INIT, CALC_J, SWAP, DONE.
REQ-013 SHALL move IDLE->INIT on the edge where start=1, latch key/key_len, clear k, i and j to 0, and clear sbox_valid.
REQ-014 SHALL, in INIT, write S[k]=k for one entry per cycle with k=0..15, then go to CALC_J after exactly 16 cycles.
REQ-015 SHALL, in CALC_J, register j <= (j + S[i] + K[i mod key_len]) mod 16 (4-bit wrap), then go to SWAP.
REQ-016 SHALL, in SWAP, exchange S[i] and S[j] in one cycle; i==j leaves S unchanged; then go to CALC_J with i+1 if i<15, otherwise to DONE.
REQ-017 SHALL, in DONE, assert done and set sbox_valid for one cycle, then return to IDLE.
REQ-018 SHALL produce a total latency of 49 cycles from the start-accept edge to the done cycle (16 INIT + 32 CALC_J/SWAP + 1 DONE).
REQ-019 SHALL ignore start while busy=1; start held high in DONE is not accepted until IDLE.
REQ-020 SHALL track the key index as a separate counter that wraps to 0 at key_len-1, with no divider.
REQ-021 SHALL keep sbox_valid=1 from DONE until the next accepted start or reset.
REQ-022 SHALL leave rd_data reading intermediate contents while busy; only sbox_valid qualifies the data.

Reset
REQ-023 SHALL, while reset=0, force state=IDLE, busy=0, done=0, sbox_valid=0, i=j=k=0, and all S entries to 0, asynchronously.
REQ-024 SHALL abort any sequence when reset is asserted mid-run; after release the FSM is in IDLE and requires a new start.
REQ-025 SHALL release reset synchronously to clk by assumption of the top-level reset synchronizer; no internal synchronizer.

Structure
REQ-026 SHALL place FSM state encoding, SBOX_DEPTH=16 and NIBBLE_W=4 in shared package rc4_pkg.
REQ-027 SHALL implement the S-box storage with read port and two-entry exchange write as sub-module sbox_regfile; the controller holds the FSM, counters and j accumulator.

Verification
REQ-028 SHALL verify: key=0, key_len=1, start pulse -> done at cycle 49; S[0..3]=0,6,3,14; S[15]=10; full S = 0,6,3,14,9,2,1,8,15,5,13,12,7,11,4,10.
REQ-029 SHALL verify: start held high for 100 cycles -> exactly two schedules run, done pulses 50 cycles apart (1 IDLE cycle between runs).
REQ-030 SHALL verify: reset=0 at cycle 20 of a run -> busy=0, sbox_valid=0, all S=0 immediately; no done pulse.
REQ-031 SHALL verify: key_len=0 vs key_len=16 with same random key -> identical S, matching golden model, S is a permutation of 0..15.
REQ-032 SHALL verify: key_len=3, key nibbles 0xA,0x5,0xF -> K index sequence 0,1,2,0,...; final S matches golden model.
REQ-033 SHALL verify: start pulsed during CALC_J -> no effect; latency still 49 cycles, result unchanged.
